// File: rtl/htpa_pkg.sv
// rtl/htpa_pkg.sv - shared state encoding and constants for the HTPA MISO receive path
package htpa_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } htpa_state_e;

  // Header lengths in SCLK samples
  localparam int HDR_CMD_DEF = 8;
  localparam int HDR_EE_DEF  = 24;

  // EEPROM instruction codes
  localparam logic [7:0] EE_READ = 8'd3;
  localparam logic [7:0] EE_WRDI = 8'd4;
  localparam logic [7:0] EE_RDSR = 8'd5;
  localparam logic [7:0] EE_WREN = 8'd6;

  // Matrix reads and RDSR carry only the command byte; EEPROM READ adds a 16-bit address.
  function automatic int hdr_bits(input logic eeprom_cs, input logic [7:0] adr,
                                  input int hdr_cmd, input int hdr_ee);
    if (!eeprom_cs || adr == EE_RDSR) return hdr_cmd;
    return hdr_ee;
  endfunction

endpackage

// File: rtl/htpa_miso_rx_if.sv
// rtl/htpa_miso_rx_if.sv - transaction, serial and receive-byte signals of the MISO receiver
interface htpa_miso_rx_if #(
  parameter int LEN_W = 12
) ();

  logic             cs_active;
  logic             eeprom_cs;
  logic             rd;
  logic [7:0]       adr;
  logic [LEN_W-1:0] len;
  logic             sclk_rise;
  logic             miso;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_last;
  logic             busy;
  logic             done;
  logic             abort;

  // SPI master side: starts transactions, supplies serial samples, consumes bytes
  modport master (
    output cs_active, eeprom_cs, rd, adr, len, sclk_rise, miso,
    input  rx_data, rx_valid, rx_last, busy, done, abort
  );

  // Receiver side
  modport slave (
    input  cs_active, eeprom_cs, rd, adr, len, sclk_rise, miso,
    output rx_data, rx_valid, rx_last, busy, done, abort
  );

endinterface

// File: rtl/htpa_shift_in.sv
// rtl/htpa_shift_in.sv - 8-bit MSB-first shift register with bit counter and byte-complete strobe
module htpa_shift_in (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       miso,
  output logic [7:0] byte_data,
  output logic       byte_done
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  // byte_done fires on the eighth shift; the full byte sits in byte_data the following cycle
  assign byte_done = shift_en && (bit_cnt_q == 3'd7);
  assign byte_data = sr_q;

  // Shift in at bit 0; clear drops any partial byte
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      sr_d      = 8'h00;
      bit_cnt_d = 3'd0;
    end else if (shift_en) begin
      sr_d      = {sr_q[6:0], miso};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // Shift register and bit counter state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/htpa_miso_rx.sv
// rtl/htpa_miso_rx.sv - HTPA SPI MISO receiver: header skip, byte assembly, done/abort reporting
module htpa_miso_rx
  import htpa_pkg::*;
#(
  parameter int LEN_W   = 12,
  parameter int HDR_CMD = HDR_CMD_DEF,
  parameter int HDR_EE  = HDR_EE_DEF
) (
  input logic           clk,
  input logic           rst_n,
  htpa_miso_rx_if.slave bus
);

  localparam int HDR_MAX = (HDR_EE > HDR_CMD) ? HDR_EE : HDR_CMD;
  localparam int HDR_W   = $clog2(HDR_MAX + 1);

  htpa_state_e      state_q, state_d;
  logic             cs_q, cs_d;
  logic [HDR_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_last_q, rx_last_d;
  logic             abort_q, abort_d;

  logic             cs_rise;
  logic             cs_lost;
  logic             shift_en;
  logic             shift_clr;
  logic             byte_done;
  logic [7:0]       byte_data;

  assign cs_d      = bus.cs_active;
  assign cs_rise   = bus.cs_active && !cs_q;
  assign cs_lost   = !bus.cs_active && (state_q == ST_SKIP || state_q == ST_SHIFT);
  // A sample coinciding with loss of chip select is discarded so abort wins
  assign shift_en  = (state_q == ST_SHIFT) && bus.sclk_rise && bus.cs_active;
  assign shift_clr = (state_q != ST_SHIFT);

  htpa_shift_in u_shift_in (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (shift_clr),
    .shift_en  (shift_en),
    .miso      (bus.miso),
    .byte_data (byte_data),
    .byte_done (byte_done)
  );

  // Next state, header/byte counters and receive strobes
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_data_d  = rx_valid_q ? byte_data : rx_data_q;
    rx_valid_d = 1'b0;
    rx_last_d  = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_rise && bus.rd) begin
          state_d    = ST_SKIP;
          hdr_cnt_d  = HDR_W'(hdr_bits(bus.eeprom_cs, bus.adr, HDR_CMD, HDR_EE));
          byte_cnt_d = bus.len;
        end
      end
      ST_SKIP: begin
        if (cs_lost) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (bus.sclk_rise) begin
          hdr_cnt_d = hdr_cnt_q - HDR_W'(1);
          if (hdr_cnt_q == HDR_W'(1)) begin
            state_d = (byte_cnt_q == '0) ? ST_FINISH : ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (cs_lost) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (byte_done) begin
          rx_valid_d = 1'b1;
          byte_cnt_d = byte_cnt_q - LEN_W'(1);
          if (byte_cnt_q == LEN_W'(1)) begin
            rx_last_d = 1'b1;
            state_d   = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; cs_q keeps tracking the line during reset so a
  // chip select still high after reset is not mistaken for a new transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cs_q       <= cs_d;
      hdr_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      hdr_cnt_q  <= hdr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_last_q  <= rx_last_d;
      abort_q    <= abort_d;
    end
  end

  // The shift register still holds the completed byte during the rx_valid cycle
  assign bus.rx_data  = rx_valid_q ? byte_data : rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_last  = rx_last_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_FINISH);
  assign bus.abort    = abort_q;

endmodule

// File: doc/htpa_miso_rx.md
HTPA_MISO_RX -- requirements
Module: htpa_miso_rx

Interface
REQ-001 SHALL have parameter LEN_W, default 12: width of the receive byte count.
REQ-002 SHALL have parameter HDR_CMD, default 8: header bits discarded for matrix reads and EEPROM RDSR.
REQ-003 SHALL have parameter HDR_EE, default 24: header bits discarded for EEPROM READ (8-bit instruction plus 16-bit address).
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 cs_active  in  1  SPI transaction in progress; the rising edge starts a transaction.
REQ-007 eeprom_cs  in  1  target: 0 = sensor matrix, 1 = EEPROM; sampled at cs_active rise.
REQ-008 rd  in  1  1 = read transaction, 0 = write; sampled at cs_active rise.
REQ-009 adr  in  8  EEPROM instruction code (5 = RDSR); sampled at cs_active rise.
REQ-010 len  in  LEN_W  number of data bytes to receive; sampled at cs_active rise.
REQ-011 sclk_rise  in  1  one-clk pulse marking the SPI sample point.
REQ-012 miso  in  1  serial data from the slave, already synchronised to clk.
REQ-013 rx_data  out  8  assembled byte, MSB first.
REQ-014 rx_valid  out  1  one-clk pulse; rx_data is valid while it is high.
REQ-015 rx_last  out  1  high together with rx_valid on the final byte.
REQ-016 busy  out  1  high from the transaction start until IDLE is re-entered.
REQ-017 done  out  1  one-clk pulse when all len bytes have been received.
REQ-018 abort  out  1  one-clk pulse when cs_active falls before completion.

Function
REQ-019 States SHALL be IDLE, SKIP, SHIFT, FINISH.
- IDLE -> SKIP on cs_active 0->1 when rd=1.
- IDLE stays in IDLE when rd=0 (write: no receive data).
REQ-020 Header length SHALL be latched on entry to SKIP:
- HDR_CMD when eeprom_cs=0;
- HDR_CMD when eeprom_cs=1 and adr=5;
- HDR_EE otherwise.
REQ-021 SKIP SHALL count sclk_rise pulses and discard miso.
- On the final header pulse: go to SHIFT, or to FINISH if the latched len=0.
REQ-022 SHIFT SHALL shift miso into bit 0 on each sclk_rise (MSB first).
- After the 8th bit, on the next clk: rx_valid=1 and rx_data = the completed byte.
REQ-023 The byte counter SHALL decrement per completed byte.
- On the last byte: rx_last=1 and the state goes to FINISH.
REQ-024 FINISH SHALL pulse done for one clk, then go to IDLE; done and the last rx_valid SHALL be in the same cycle (len≥1).
REQ-025 cs_active=0 in SKIP or SHIFT SHALL drop any partial byte, pulse abort for one clk and go to IDLE; abort has priority over a coincident sclk_rise.
REQ-026 sclk_rise in IDLE or FINISH SHALL be ignored.
REQ-027 len=2^LEN_W-1 SHALL be supported; the counter SHALL NOT wrap during a transaction.
REQ-028 A new cs_active rise SHALL be accepted only in IDLE (minimum one idle clk after done/abort).
REQ-029 rx_data SHALL hold its last value between rx_valid pulses.

Reset
REQ-030 With rst_n=0 at a clk edge, the state SHALL be IDLE and rx_data=0, with rx_valid, rx_last, busy, done and abort all 0; the shift and byte counters SHALL be cleared.
REQ-031 Reset mid-transaction SHALL NOT produce done or abort.
- The module SHALL wait in IDLE for the next cs_active rise, even if cs_active is still high.

Structure
REQ-032 A shared package htpa_pkg SHALL hold:
- the state enumeration;
- HDR_CMD and HDR_EE defaults;
- EEPROM instruction constants (RDSR=5, READ=3, WREN=6, WRDI=4).
REQ-033 A single sub-module htpa_shift_in SHALL hold the 8-bit shift register and the 3-bit bit counter, with a byte-complete strobe; the FSM and byte counter stay in the top.

Verification
REQ-034 Matrix read, eeprom_cs=0, rd=1, len=2, MISO = 8 header bits then 0xA5, 0x3C -> rx_valid twice with 0xA5 then 0x3C; rx_last and done together on the 2nd byte.
REQ-035 EEPROM READ, eeprom_cs=1, adr=3, len=1, 24 header bits then 0x7E -> exactly one rx_valid, data 0x7E, 25th to 32nd samples only.
REQ-036 EEPROM RDSR, adr=5, len=1, status 0x02 after 8 bits -> rx_data=0x02, done.
REQ-037 Write transaction, rd=0, 40 sclk_rise pulses -> busy stays 0; no rx_valid, done or abort.
REQ-038 Matrix read len=3, cs_active dropped after 13 data bits -> one rx_valid, abort pulse, no done, IDLE next clk.
REQ-039 rst_n=0 during SHIFT with len=4 -> all outputs 0; cs_active held high -> no activity until a fresh rise.
